// File: rtl/ball_controller.sv
// rtl/ball_controller.sv - per-frame pitch-to-height ball controller with collision/lives FSM
module ball_controller #(
    parameter int Y_HEIGHT   = 600,
    parameter int Y_MIN      = 16,
    parameter int Y_MAX      = 704,
    parameter int MAX_STEP   = 8,
    parameter int HIT_FRAMES = 60,
    parameter int LIVES      = 3
) (
    input  logic        clk_pixel,
    input  logic        rst_in,
    input  logic        new_frame_in,
    input  logic [15:0] freq_in,
    input  logic        freq_valid_in,
    input  logic        start_in,
    input  logic        ball_px_in,
    input  logic        pipe_px_in,
    output logic [9:0]  ball_y_out,
    output logic [1:0]  state_out,
    output logic [1:0]  lives_out,
    output logic [15:0] frames_out,
    output logic        hit_out
);
    localparam int CW = $clog2(HIT_FRAMES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_HIT  = 2'd2,
        S_OVER = 2'd3
    } state_t;

    state_t        r_state;
    logic [9:0]    r_ball_y;
    logic [9:0]    r_target;
    logic [1:0]    r_lives;
    logic [15:0]   r_frames;
    logic          r_hit;
    logic [15:0]   r_freq_lat;
    logic          r_hit_flag;
    logic [CW-1:0] r_hit_cnt;

    logic [8:0]         w_pos;
    logic signed [10:0] w_raw;
    logic [9:0]         w_target_next;
    logic signed [11:0] w_d;
    logic [9:0]         w_ball_next;
    logic               w_overlap;
    logic               w_hit;

    assign w_pos     = r_freq_lat[9:1];
    assign w_raw     = 11'(Y_HEIGHT) - 11'({2'b00, w_pos});
    assign w_overlap = ball_px_in & pipe_px_in;
    // Overlap seen on the new_frame_in cycle itself still belongs to the ending frame.
    assign w_hit     = r_hit_flag | w_overlap;
    assign w_d       = $signed({2'b00, r_target}) - $signed({2'b00, r_ball_y});

    always_comb begin
        w_target_next = w_raw[9:0];
        if (w_raw < $signed(11'(Y_MIN)))
            w_target_next = 10'(Y_MIN);
        else if (w_raw > $signed(11'(Y_MAX)))
            w_target_next = 10'(Y_MAX);
    end

    always_comb begin
        w_ball_next = r_target;
        if (w_d > $signed(12'(MAX_STEP)))
            w_ball_next = r_ball_y + 10'(MAX_STEP);
        else if (w_d < -$signed(12'(MAX_STEP)))
            w_ball_next = r_ball_y - 10'(MAX_STEP);
    end

    always_ff @(posedge clk_pixel or posedge rst_in) begin
        if (rst_in) begin
            r_freq_lat <= '0;
            r_target   <= 10'(Y_HEIGHT);
        end else begin
            if (freq_valid_in)
                r_freq_lat <= freq_in;
            r_target <= w_target_next;
        end
    end

    always_ff @(posedge clk_pixel or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= S_IDLE;
            r_ball_y   <= 10'(Y_HEIGHT);
            r_lives    <= 2'(LIVES);
            r_frames   <= '0;
            r_hit      <= 1'b0;
            r_hit_flag <= 1'b0;
            r_hit_cnt  <= '0;
        end else begin
            r_hit <= 1'b0;
            case (r_state)
                S_IDLE, S_OVER: begin
                    r_hit_flag <= 1'b0;
                    if (start_in) begin
                        r_state  <= S_PLAY;
                        r_lives  <= 2'(LIVES);
                        r_frames <= '0;
                        r_ball_y <= 10'(Y_HEIGHT);
                    end
                end
                S_PLAY: begin
                    if (new_frame_in) begin
                        r_hit_flag <= 1'b0;
                        if (w_hit) begin
                            r_hit   <= 1'b1;
                            r_lives <= r_lives - 2'd1;
                            if (r_lives == 2'd1) begin
                                r_state <= S_OVER;
                            end else begin
                                r_state   <= S_HIT;
                                r_hit_cnt <= CW'(HIT_FRAMES - 1);
                            end
                        end else begin
                            r_ball_y <= w_ball_next;
                            if (r_frames != 16'hFFFF)
                                r_frames <= r_frames + 16'd1;
                        end
                    end else if (w_overlap) begin
                        r_hit_flag <= 1'b1;
                    end
                end
                S_HIT: begin
                    r_hit_flag <= 1'b0;
                    if (new_frame_in) begin
                        if (r_hit_cnt == '0)
                            r_state <= S_PLAY;
                        else
                            r_hit_cnt <= r_hit_cnt - CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ball_y_out = r_ball_y;
    assign state_out  = r_state;
    assign lives_out  = r_lives;
    assign frames_out = r_frames;
    assign hit_out    = r_hit;
endmodule

// File: tb/tb_ball_controller.sv
// tb/tb_ball_controller.sv - directed table and sequence bench for ball_controller
module tb_ball_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nf = 1'b0;
    logic [15:0] freq = '0;
    logic        fv = 1'b0;
    logic        start = 1'b0;
    logic        bpx = 1'b0;
    logic        ppx = 1'b0;

    logic [9:0]  ball_y, ball_y2;
    logic [1:0]  state, state2, lives, lives2;
    logic [15:0] frames, frames2;
    logic        hit, hit2;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_frames;

    always #5 clk = ~clk;

    ball_controller dut (
        .clk_pixel(clk), .rst_in(rst), .new_frame_in(nf), .freq_in(freq),
        .freq_valid_in(fv), .start_in(start), .ball_px_in(bpx), .pipe_px_in(ppx),
        .ball_y_out(ball_y), .state_out(state), .lives_out(lives),
        .frames_out(frames), .hit_out(hit)
    );

    // Narrow window so both clamps are reachable with normal pitch values.
    ball_controller #(.Y_MIN(200), .Y_MAX(590)) dut2 (
        .clk_pixel(clk), .rst_in(rst), .new_frame_in(nf), .freq_in(freq),
        .freq_valid_in(fv), .start_in(start), .ball_px_in(bpx), .pipe_px_in(ppx),
        .ball_y_out(ball_y2), .state_out(state2), .lives_out(lives2),
        .frames_out(frames2), .hit_out(hit2)
    );

    typedef struct {
        int freq;
        int nfr;
        int exp_y;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames_run(input int n);
        for (int i = 0; i < n; i++) begin
            nf = 1'b1;
            tick();
            nf = 1'b0;
            tick();
            tick();
        end
    endtask

    task automatic set_freq(input int f);
        freq = 16'(f);
        fv = 1'b1;
        tick();
        fv = 1'b0;
        tick();
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    // Overlap only on the new_frame_in cycle.
    task automatic hit_on_pulse();
        nf = 1'b1;
        bpx = 1'b1;
        ppx = 1'b1;
        tick();
        nf = 1'b0;
        bpx = 1'b0;
        ppx = 1'b0;
    endtask

    initial begin
        int y_frozen;

        vecs[0] = '{0,     1,  508};
        vecs[1] = '{0,     12, 600};
        vecs[2] = '{1400,  1,  592};
        vecs[3] = '{1400,  23, 412};
        vecs[4] = '{2000,  38, 112};
        vecs[5] = '{65535, 1,  104};
        vecs[6] = '{65535, 2,  89};
        vecs[7] = '{1006,  1,  97};
        vecs[8] = '{988,   1,  105};

        tick();
        tick();
        chk("reset_state", int'(state), 0);
        chk("reset_ball_y", int'(ball_y), 600);
        chk("reset_lives", int'(lives), 3);
        chk("reset_frames", int'(frames), 0);
        chk("reset_hit", int'(hit), 0);
        rst = 1'b0;
        tick();

        frames_run(1);
        chk("idle_ignores_frame_state", int'(state), 0);
        chk("idle_ignores_frame_y", int'(ball_y), 600);

        pulse_start();
        chk("start_to_play", int'(state), 1);
        set_freq(200);
        frames_run(1);
        chk("first_step_y", int'(ball_y), 592);
        chk("first_step_frames", int'(frames), 1);
        frames_run(12);
        chk("settle_500", int'(ball_y), 500);
        frames_run(1);
        chk("hold_500", int'(ball_y), 500);
        exp_frames = 14;
        chk("frames_14", int'(frames), exp_frames);

        for (int i = 0; i < 9; i++) begin
            set_freq(vecs[i].freq);
            frames_run(vecs[i].nfr);
            exp_frames += vecs[i].nfr;
            chk($sformatf("vec%0d_ball_y", i), int'(ball_y), vecs[i].exp_y);
            chk($sformatf("vec%0d_frames", i), int'(frames), exp_frames);
            if (i == 1)
                chk("clamp_ymax_590", int'(ball_y2), 590);
        end
        frames_run(1);
        exp_frames += 1;
        chk("step9_to_106", int'(ball_y), 106);
        chk("clamp_ymin_200", int'(ball_y2), 200);

        // Mid-frame single-cycle overlap, registered at the next frame pulse.
        bpx = 1'b1;
        ppx = 1'b1;
        tick();
        bpx = 1'b0;
        ppx = 1'b0;
        tick();
        nf = 1'b1;
        tick();
        nf = 1'b0;
        chk("hit_pulse", int'(hit), 1);
        chk("hit_lives", int'(lives), 2);
        chk("hit_state", int'(state), 2);
        tick();
        chk("hit_pulse_single", int'(hit), 0);
        y_frozen = int'(ball_y);
        set_freq(0);
        bpx = 1'b1;
        ppx = 1'b1;
        frames_run(59);
        bpx = 1'b0;
        ppx = 1'b0;
        chk("hit_59_state", int'(state), 2);
        chk("hit_frozen_y", int'(ball_y), y_frozen);
        chk("hit_frames_held", int'(frames), exp_frames);
        chk("hit_ignores_overlap", int'(lives), 2);
        frames_run(1);
        chk("hit_60_back_play", int'(state), 1);
        chk("hit_60_y", int'(ball_y), y_frozen);
        frames_run(1);
        chk("post_hit_slew", int'(ball_y), y_frozen + 8);
        chk("post_hit_frames", int'(frames), exp_frames + 1);
        chk("post_hit_no_rehit", int'(state), 1);

        hit_on_pulse();
        chk("pulse_hit_lives1", int'(lives), 1);
        tick();
        frames_run(60);
        chk("back_play_lives1", int'(state), 1);
        y_frozen = int'(ball_y);
        hit_on_pulse();
        chk("last_hit_pulse", int'(hit), 1);
        chk("over_state", int'(state), 3);
        chk("over_lives", int'(lives), 0);
        tick();
        frames_run(3);
        chk("over_hold_state", int'(state), 3);
        chk("over_hold_y", int'(ball_y), y_frozen);
        pulse_start();
        chk("restart_state", int'(state), 1);
        chk("restart_lives", int'(lives), 3);
        chk("restart_frames", int'(frames), 0);
        chk("restart_y", int'(ball_y), 600);

        // Asynchronous reset with hit_cnt at 30.
        hit_on_pulse();
        tick();
        frames_run(29);
        chk("pre_reset_hit_state", int'(state), 2);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_y", int'(ball_y), 600);
        chk("async_rst_lives", int'(lives), 3);
        chk("async_rst_frames", int'(frames), 0);
        chk("async_rst_hit", int'(hit), 0);
        tick();
        rst = 1'b0;
        tick();

        // Start and frame pulse together: start wins, no slew.
        start = 1'b1;
        nf = 1'b1;
        tick();
        start = 1'b0;
        nf = 1'b0;
        tick();
        chk("start_wins_state", int'(state), 1);
        chk("start_wins_frames", int'(frames), 0);
        frames_run(1);
        chk("freq_lat_reset_y", int'(ball_y), 600);
        chk("freq_lat_reset_frames", int'(frames), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
